// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, ALU op codes, FSM
// state encoding, write-back payload struct and op-classification helpers.
package mem_stage_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned SEL_W      = 4;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;
    localparam logic [REG_W-1:0]      ZERO_WORD    = 32'h0000_0000;

    // Memory op codes (EXE_*_OP)
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUS  = 1'b1
    } mem_state_e;

    // Write-back triple toward the WB stage
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic [REG_W-1:0]      wdata;
        logic                  wreg;
    } wb_t;

    localparam wb_t WB_BUBBLE = '{wd: NOP_REG_ADDR, wdata: ZERO_WORD, wreg: 1'b0};

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes never fault
    function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op,
                                           input logic [1:0]         addr_lo);
        logic half;
        logic word;
        half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
        word = (op == EXE_LW_OP) || (op == EXE_SW_OP);
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_load_fmt.sv
// mem_load_fmt: combinational lane steering for the data bus.
//  aluop        in   op code
//  addr_lo      in   address bits [1:0]
//  rdata        in   raw bus read data
//  sdata        in   raw store data (rt)
//  load_data_c  out  extracted/extended load result (rdata for non-loads)
//  sel_c        out  big-endian byte lanes for the access
//  store_data_c out  store data replicated across lanes
module mem_load_fmt
    import mem_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [REG_W-1:0]   rdata,
    input  logic [REG_W-1:0]   sdata,
    output logic [REG_W-1:0]   load_data_c,
    output logic [SEL_W-1:0]   sel_c,
    output logic [REG_W-1:0]   store_data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [SEL_W-1:0] byte_sel;
    logic [SEL_W-1:0] half_sel;

    // Big-endian lane pick: offset 0 is bits 31:24
    always_comb begin
        byte_lane = rdata[31:24];
        case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        byte_sel  = 4'b1000 >> addr_lo;
        half_sel  = addr_lo[1] ? 4'b0011 : 4'b1100;
    end

    // Per-op formatting
    always_comb begin
        load_data_c  = rdata;
        sel_c        = '0;
        store_data_c = sdata;
        case (aluop)
            EXE_LB_OP: begin
                load_data_c = {{24{byte_lane[7]}}, byte_lane};
                sel_c       = byte_sel;
            end
            EXE_LBU_OP: begin
                load_data_c = {24'h000000, byte_lane};
                sel_c       = byte_sel;
            end
            EXE_LH_OP: begin
                load_data_c = {{16{half_lane[15]}}, half_lane};
                sel_c       = half_sel;
            end
            EXE_LHU_OP: begin
                load_data_c = {16'h0000, half_lane};
                sel_c       = half_sel;
            end
            EXE_LW_OP: begin
                sel_c = 4'b1111;
            end
            EXE_SB_OP: begin
                sel_c        = byte_sel;
                store_data_c = {4{sdata[7:0]}};
            end
            EXE_SH_OP: begin
                sel_c        = half_sel;
                store_data_c = {2{sdata[15:0]}};
            end
            EXE_SW_OP: begin
                sel_c = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline. Runs loads/stores on a
// req/ack data bus, stalls upstream until each access completes, and
// registers the write-back triple toward WB.
//  clk, rst        clock / synchronous active-high reset
//  mem_*           EX/MEM register outputs (wd, wdata, wreg, aluop, addr, sdata)
//  dbus_rdata/ack  bus read data and single-cycle completion pulse
//  dbus_*          registered bus request, direction, address, lanes, data
//  stall_req       combinational hold request to pipeline control
//  wb_*            registered write-back triple
//  addr_err        pulse on misaligned access; bus_err pulse on timeout abort
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic [REG_W-1:0]      mem_wdata,
    input  logic                  mem_wreg,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [REG_W-1:0]      mem_addr,
    input  logic [REG_W-1:0]      mem_sdata,
    input  logic [REG_W-1:0]      dbus_rdata,
    input  logic                  dbus_ack,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [REG_W-1:0]      dbus_addr,
    output logic [SEL_W-1:0]      dbus_sel,
    output logic [REG_W-1:0]      dbus_wdata,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic [REG_W-1:0]      wb_wdata,
    output logic                  wb_wreg,
    output logic                  addr_err,
    output logic                  bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbus_req_q, dbus_req_d;
    logic             dbus_we_q, dbus_we_d;
    logic [REG_W-1:0] dbus_addr_q, dbus_addr_d;
    logic [SEL_W-1:0] dbus_sel_q, dbus_sel_d;
    logic [REG_W-1:0] dbus_wdata_q, dbus_wdata_d;
    wb_t              wb_q, wb_d;
    logic             addr_err_q, addr_err_d;
    logic             bus_err_q, bus_err_d;

    logic [REG_W-1:0] load_data_c;
    logic [SEL_W-1:0] sel_c;
    logic [REG_W-1:0] store_data_c;
    logic             mem_op_c;
    logic             timeout_c;

    mem_load_fmt u_fmt (
        .aluop       (mem_aluop),
        .addr_lo     (mem_addr[1:0]),
        .rdata       (dbus_rdata),
        .sdata       (mem_sdata),
        .load_data_c (load_data_c),
        .sel_c       (sel_c),
        .store_data_c(store_data_c)
    );

    assign mem_op_c  = is_load(mem_aluop) || is_store(mem_aluop);
    assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_sel_d   = dbus_sel_q;
        dbus_wdata_d = dbus_wdata_q;
        wb_d         = wb_q;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;
        stall_req    = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                cnt_d = '0;
                if (mem_op_c) begin
                    wb_d = WB_BUBBLE;
                    if (is_misaligned(mem_aluop, mem_addr[1:0])) begin
                        addr_err_d = 1'b1;
                    end else begin
                        stall_req    = 1'b1;
                        dbus_req_d   = 1'b1;
                        dbus_we_d    = is_store(mem_aluop);
                        dbus_addr_d  = {mem_addr[31:2], 2'b00};
                        dbus_sel_d   = sel_c;
                        dbus_wdata_d = store_data_c;
                        state_d      = MEM_BUS;
                    end
                end else begin
                    wb_d = '{wd: mem_wd, wdata: mem_wdata, wreg: mem_wreg};
                end
            end

            MEM_BUS: begin
                stall_req = !dbus_ack;
                cnt_d     = cnt_q + CNT_W'(1);
                if (dbus_ack) begin
                    wb_d       = '{wd: mem_wd, wdata: load_data_c,
                                   wreg: mem_wreg & is_load(mem_aluop)};
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = MEM_IDLE;
                end else if (timeout_c) begin
                    // Abort: release the pipeline this cycle, drop the op
                    stall_req  = 1'b0;
                    wb_d       = WB_BUBBLE;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = MEM_IDLE;
                end
            end

            default: state_d = MEM_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MEM_IDLE;
            cnt_q        <= '0;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= ZERO_WORD;
            dbus_sel_q   <= '0;
            dbus_wdata_q <= ZERO_WORD;
            wb_q         <= WB_BUBBLE;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_sel_q   <= dbus_sel_d;
            dbus_wdata_q <= dbus_wdata_d;
            wb_q         <= wb_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_sel   = dbus_sel_q;
    assign dbus_wdata = dbus_wdata_q;
    assign wb_wd      = wb_q.wd;
    assign wb_wdata   = wb_q.wdata;
    assign wb_wreg    = wb_q.wreg;
    assign addr_err   = addr_err_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard queue.
module tb_mem_stage;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_wreg;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        stall_req;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_wreg;
    logic        addr_err;
    logic        bus_err;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        wreg;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wd    (mem_wd),
        .mem_wdata (mem_wdata),
        .mem_wreg  (mem_wreg),
        .mem_aluop (mem_aluop),
        .mem_addr  (mem_addr),
        .mem_sdata (mem_sdata),
        .dbus_rdata(dbus_rdata),
        .dbus_ack  (dbus_ack),
        .dbus_req  (dbus_req),
        .dbus_we   (dbus_we),
        .dbus_addr (dbus_addr),
        .dbus_sel  (dbus_sel),
        .dbus_wdata(dbus_wdata),
        .stall_req (stall_req),
        .wb_wd     (wb_wd),
        .wb_wdata  (wb_wdata),
        .wb_wreg   (wb_wreg),
        .addr_err  (addr_err),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic wreg, input logic [31:0] addr, input logic [31:0] sdata);
        mem_aluop = op;
        mem_wd    = wd;
        mem_wdata = wdata;
        mem_wreg  = wreg;
        mem_addr  = addr;
        mem_sdata = sdata;
    endtask

    task automatic push(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg,
                        input logic chk_data);
        exp_t e;
        e.wd = wd; e.wdata = wdata; e.wreg = wreg; e.chk_data = chk_data;
        sb.push_back(e);
    endtask

    task automatic pop_wb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wd"},   32'(wb_wd),   32'(e.wd));
            chk({tag, "_wreg"}, 32'(wb_wreg), 32'(e.wreg));
            if (e.chk_data) chk({tag, "_wdata"}, wb_wdata, e.wdata);
        end
    endtask

    // Op already driven in IDLE; ack on the ack_after-th BUS cycle.
    // Returns stall cycles and the bus fields seen in the first BUS cycle.
    task automatic mem_access(input int ack_after, input logic [31:0] rdata,
                              output int stalls, output logic req, output logic we,
                              output logic [31:0] addr, output logic [3:0] sel,
                              output logic [31:0] wdata);
        #1;
        stalls = stall_req ? 1 : 0;
        tick();
        req = dbus_req; we = dbus_we; addr = dbus_addr; sel = dbus_sel; wdata = dbus_wdata;
        for (int k = 1; k <= ack_after; k++) begin
            if (k == ack_after) begin
                dbus_ack   = 1'b1;
                dbus_rdata = rdata;
            end
            #1;
            if (stall_req) stalls++;
            tick();
            dbus_ack = 1'b0;
        end
        drive(OP_NOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int          stalls;
        int          n_bus;
        logic        last_stall;
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  sel;

        rst = 1'b1;
        dbus_ack = 1'b0;
        dbus_rdata = 32'd0;
        drive(OP_NOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();

        // Reset state
        chk("rst_req",   32'(dbus_req), 32'd0);
        chk("rst_sel",   32'(dbus_sel), 32'd0);
        chk("rst_wd",    32'(wb_wd),    32'd0);
        chk("rst_wreg",  32'(wb_wreg),  32'd0);
        chk("rst_errs",  32'({addr_err, bus_err}), 32'd0);

        // Pass-through ops
        rst = 1'b0;
        drive(OP_ADD, 5'd3, 32'h1234_5678, 1'b1, 32'h0, 32'h0);
        push(5'd3, 32'h1234_5678, 1'b1, 1'b1);
        #1;
        chk("add_stall", 32'(stall_req), 32'd0);
        tick();
        pop_wb("add");
        drive(OP_OR, 5'd31, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
        push(5'd31, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tick();
        pop_wb("or");

        // LB, ack on third BUS cycle
        drive(OP_LB, 5'd7, 32'h0, 1'b1, 32'h0000_0101, 32'h0);
        push(5'd7, 32'hFFFF_FF80, 1'b1, 1'b1);
        mem_access(3, 32'h0080_FF00, stalls, req, we, addr, sel, wdata);
        pop_wb("lb");
        chk("lb_stalls", 32'(stalls), 32'd3);
        chk("lb_req",    32'(req),    32'd1);
        chk("lb_sel",    32'(sel),    32'b0100);
        chk("lb_addr",   addr,        32'h0000_0100);
        chk("lb_req_drop", 32'(dbus_req), 32'd0);

        // LHU, ack on first BUS cycle
        drive(OP_LHU, 5'd9, 32'h0, 1'b1, 32'h0000_0102, 32'h0);
        push(5'd9, 32'h0000_8001, 1'b1, 1'b1);
        mem_access(1, 32'hAAAA_8001, stalls, req, we, addr, sel, wdata);
        pop_wb("lhu");
        chk("lhu_stalls", 32'(stalls), 32'd1);
        chk("lhu_sel",    32'(sel),    32'b0011);

        // SB to the last byte lane
        drive(OP_SB, 5'd4, 32'h0, 1'b1, 32'h0000_0203, 32'h0000_00EE);
        push(5'd4, 32'h0, 1'b0, 1'b0);
        mem_access(2, 32'h1357_9BDF, stalls, req, we, addr, sel, wdata);
        pop_wb("sb");
        chk("sb_we",    32'(we),  32'd1);
        chk("sb_sel",   32'(sel), 32'b0001);
        chk("sb_wdata", wdata,    32'hEEEE_EEEE);
        chk("sb_addr",  addr,     32'h0000_0200);

        // SH upper half
        drive(OP_SH, 5'd6, 32'h0, 1'b1, 32'h0000_0204, 32'h1234_ABCD);
        push(5'd6, 32'h0, 1'b0, 1'b0);
        mem_access(1, 32'h0, stalls, req, we, addr, sel, wdata);
        pop_wb("sh");
        chk("sh_sel",   32'(sel), 32'b1100);
        chk("sh_wdata", wdata,    32'hABCD_ABCD);

        // Misaligned LW
        drive(OP_LW, 5'd8, 32'h0, 1'b1, 32'h0000_0102, 32'h0);
        #1;
        chk("mis_stall", 32'(stall_req), 32'd0);
        tick();
        chk("mis_req",   32'(dbus_req), 32'd0);
        chk("mis_aerr",  32'(addr_err), 32'd1);
        chk("mis_wreg",  32'(wb_wreg),  32'd0);
        drive(OP_NOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("mis_aerr_pulse", 32'(addr_err), 32'd0);

        // Timeout: aligned LW with no ack
        drive(OP_LW, 5'd10, 32'h0, 1'b1, 32'h0000_0100, 32'h0);
        tick();
        n_bus = 0;
        last_stall = 1'b1;
        while (!bus_err && n_bus < 40) begin
            if (dbus_req) n_bus++;
            last_stall = stall_req;
            if (dbus_req && !stall_req) drive(OP_NOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
            tick();
        end
        chk("to_cycles",     32'(n_bus),      32'd16);
        chk("to_last_stall", 32'(last_stall), 32'd0);
        chk("to_berr",       32'(bus_err),    32'd1);
        chk("to_req",        32'(dbus_req),   32'd0);
        chk("to_wreg",       32'(wb_wreg),    32'd0);
        drive(OP_NOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("to_berr_pulse", 32'(bus_err),    32'd0);

        // Reset during BUS, then a stray ack in IDLE
        drive(OP_LW, 5'd5, 32'h0, 1'b1, 32'h0000_0300, 32'h0);
        tick();
        chk("rb_req_up", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        tick();
        chk("rb_req",   32'(dbus_req), 32'd0);
        chk("rb_wd",    32'(wb_wd),    32'd0);
        chk("rb_wdata", wb_wdata,      32'd0);
        chk("rb_wreg",  32'(wb_wreg),  32'd0);
        chk("rb_berr",  32'(bus_err),  32'd0);
        rst = 1'b0;
        drive(OP_NOP, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hCAFE_F00D;
        tick();
        dbus_ack = 1'b0;
        chk("stray_wdata", wb_wdata,      32'd0);
        chk("stray_wreg",  32'(wb_wreg),  32'd0);
        chk("stray_req",   32'(dbus_req), 32'd0);
        chk("sb_left",     32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
